wr_ptr_ctrl_sync: RTL
=====================

Name: wr_ptr_ctrl_sync

Overview:
Write-side pointer controller for the dual-clock FIFO, next generation of the basic write pointer block. Runs entirely in the write clock domain. Synchronises the raw read-domain Gray pointer internally through a parametrised flop chain and keeps the binary/Gray write pointers. Produces registered full, almost_full, fill level, free space and a sticky overflow flag, and acknowledges each accepted write. It feeds the RAM write address and sends wr_gray to the read-side controller.

Parameters:
ADDR_WIDTH, 4, RAM address bits. Depth DEPTH = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits. Legal range is ADDR_WIDTH >= 2.
SYNC_STAGES, 2, number of flops in the rd_gray synchroniser. Legal range is 2..4.
AF_LEVEL, DEPTH-2, almost_full asserts when fill level >= AF_LEVEL. Legal range is 1..DEPTH.

Ports:
clk  input  1  write-domain clock; all flops on rising edge
rst  input  1  synchronous, active-low reset
wr_en  input  1  write request
rd_gray_in  input  ADDR_WIDTH+1  raw read pointer in Gray, from read domain (asynchronous)
ovf_clr  input  1  clears sticky overflow
wr_ack  output  1  write accepted this cycle (combinational)
wr_addr  output  ADDR_WIDTH  RAM write address, wr_bin[ADDR_WIDTH-1:0]
wr_bin  output  ADDR_WIDTH+1  binary write pointer (registered)
wr_gray  output  ADDR_WIDTH+1  Gray write pointer (registered), to read domain
full  output  1  FIFO full (registered)
almost_full  output  1  fill level >= AF_LEVEL (registered)
fill_level  output  ADDR_WIDTH+1  words held, as seen from write side (registered)
free_space  output  ADDR_WIDTH+1  DEPTH - fill_level (registered)
overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset: on a rising edge with rst=0, every flop goes to 0. This covers the sync chain, wr_bin, wr_gray, full, almost_full, fill_level and overflow. free_space becomes DEPTH. Reset wins over all other inputs, including mid-stream.
- Sync chain:
  - rd_gray_in passes through SYNC_STAGES flops; rd_gray_sync is the last stage.
  - rd_bin_sync is the combinational Gray-to-binary conversion of rd_gray_sync (MSB-down XOR prefix).
- Push logic:
  - push = wr_en & ~full.
  - wr_ack = push, in the same cycle.
  - wr_bin_next = wr_bin + push, modulo 2**(ADDR_WIDTH+1).
  - wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
  - wr_bin and wr_gray load their next values every non-reset edge.
  - wr_gray changes by at most one bit per cycle.
- full:
  - full <= (wr_gray_next == {~rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_sync[ADDR_WIDTH-2:0]}).
  - The compare is registered, using the current rd_gray_sync.
  - full asserts on the same edge that stores the DEPTH-th unread word. No write is ever accepted while full=1.
- Fill level:
  - fill_next = wr_bin_next - rd_bin_sync, modulo 2**(ADDR_WIDTH+1). Range is 0..DEPTH.
  - fill_level <= fill_next.
  - free_space <= DEPTH - fill_next.
  - almost_full <= (fill_next >= AF_LEVEL).
  - full=1 exactly when fill_level == DEPTH.
- Latency of read-side release: a read-side pointer change on rd_gray_in reaches full, fill_level and almost_full SYNC_STAGES+1 write clocks later. Flags are therefore pessimistic but never optimistic.
- Overflow:
  - Set condition: wr_en & full.
  - Clear condition: ovf_clr.
  - Set wins when both occur in the same cycle.
  - Otherwise overflow holds.
  - An overflowing write does not change any pointer.
- Wrap-around: wr_bin wraps from all-ones to 0 with no special handling. The MSB toggle distinguishes full from empty.
- No state machine beyond the pointer, sync and flag registers. Implementation target is about 130 lines.

Test Plan:
(Cases use ADDR_WIDTH=4, SYNC_STAGES=2, AF_LEVEL=14.)
1. Reset: hold rst=0 for 2 cycles with wr_en=1 and a nonzero rd_gray_in -> all outputs 0, free_space=16, wr_ack=0 after release until wr_en is seen.
2. Fill from empty: rd_gray_in=0, wr_en=1 for 20 cycles -> 16 wr_ack pulses. almost_full=1 after the 14th push. full=1 after the 16th push. Final wr_bin=5'b10000, wr_gray=5'b11000, fill_level=16, free_space=0. wr_ack=0 on cycles 17..20 and overflow=1.
3. Overflow clear: while full, pulse ovf_clr with wr_en=0 -> overflow=0 next cycle. Pulse ovf_clr together with wr_en=1 -> overflow stays 1. Pointers are unchanged throughout.
4. Release latency: from full, set rd_gray_in=5'b00001 (one read) -> full falls and fill_level=15 exactly 3 clocks later, not earlier. almost_full stays 1.
5. Wrap-around streaming: writes and read-pointer advances at an equal rate for 40 words -> wr_bin wraps from 5'b11111 to 5'b00000. Every wr_gray transition is a 1-bit change. full never asserts. fill_level never exceeds 16.
6. Reset mid-operation: with fill_level=9 and overflow=1, drive rst=0 for one edge -> all flops 0 on that edge. The next push gives wr_bin=1 and wr_gray=5'b00001.

Source files
------------

// File: rtl/wr_ptr_ctrl_sync_if.sv
// Write-side pointer controller bus: write request and read pointer in,
// acknowledge, pointers, fill metrics and flags out.
//
// Signals (slave = controller side):
//   wr_en       in   write request
//   rd_gray_in  in   raw read-domain Gray pointer (asynchronous)
//   ovf_clr     in   clears sticky overflow
//   wr_ack      out  write accepted this cycle
//   wr_addr     out  RAM write address
//   wr_bin      out  binary write pointer
//   wr_gray     out  Gray write pointer, to read domain
//   full        out  FIFO full
//   almost_full out  fill level >= AF_LEVEL
//   fill_level  out  words held, write-side view
//   free_space  out  DEPTH - fill_level
//   overflow    out  sticky write-while-full flag
interface wr_ptr_ctrl_sync_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rd_gray_in;
    logic                  ovf_clr;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   wr_bin;
    logic [ADDR_WIDTH:0]   wr_gray;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   fill_level;
    logic [ADDR_WIDTH:0]   free_space;
    logic                  overflow;

    modport master (
        output wr_en,
        output rd_gray_in,
        output ovf_clr,
        input  wr_ack,
        input  wr_addr,
        input  wr_bin,
        input  wr_gray,
        input  full,
        input  almost_full,
        input  fill_level,
        input  free_space,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  rd_gray_in,
        input  ovf_clr,
        output wr_ack,
        output wr_addr,
        output wr_bin,
        output wr_gray,
        output full,
        output almost_full,
        output fill_level,
        output free_space,
        output overflow
    );
endinterface

// File: rtl/wr_ptr_ctrl_sync.sv
// Write-side pointer controller for a dual-clock FIFO: synchronises the
// read Gray pointer, keeps binary/Gray write pointers, registered flags.
//
// Ports:
//   clk  write-domain clock, rising edge
//   rst  synchronous active-low reset
//   bus  wr_ptr_ctrl_sync_if.slave (request/ack, pointers, level, flags)
module wr_ptr_ctrl_sync #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = (1 << ADDR_WIDTH) - 2
) (
    input logic               clk,
    input logic               rst,
    wr_ptr_ctrl_sync_if.slave bus
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_full;
    logic          r_af;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_free;
    logic          r_ovf;

    logic [PW-1:0] w_rd_gray_sync;
    logic [PW-1:0] w_rd_bin_sync;
    logic          w_push;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_gray;
    logic          w_full_next;
    logic [PW-1:0] w_fill_next;
    logic [PW-1:0] w_free_next;
    logic          w_af_next;
    logic          w_ovf_set;

    // Read pointer crosses into this domain through a plain flop chain;
    // Gray coding guarantees at most one bit is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.rd_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rd_gray_sync = r_sync[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        w_rd_bin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            w_rd_bin_sync[i] = ^(w_rd_gray_sync >> i);
        end
    end

    assign w_push      = bus.wr_en & ~r_full;
    assign w_bin_next  = r_bin + PW'(w_push);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Full in Gray space: top two bits inverted, the rest equal.
    assign w_full_gray = {~w_rd_gray_sync[ADDR_WIDTH -: 2],
                          w_rd_gray_sync[ADDR_WIDTH-2:0]};
    assign w_full_next = (w_gray_next == w_full_gray);

    assign w_fill_next = w_bin_next - w_rd_bin_sync;
    assign w_free_next = PW'(DEPTH) - w_fill_next;
    assign w_af_next   = (w_fill_next >= PW'(AF_LEVEL));

    assign w_ovf_set   = bus.wr_en & r_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_full <= 1'b0;
            r_af   <= 1'b0;
            r_fill <= '0;
            r_free <= PW'(DEPTH);
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_full <= w_full_next;
            r_af   <= w_af_next;
            r_fill <= w_fill_next;
            r_free <= w_free_next;
        end
    end

    // Set has priority over clear so a same-cycle overflow is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.wr_ack      = w_push;
    assign bus.wr_addr     = r_bin[ADDR_WIDTH-1:0];
    assign bus.wr_bin      = r_bin;
    assign bus.wr_gray     = r_gray;
    assign bus.full        = r_full;
    assign bus.almost_full = r_af;
    assign bus.fill_level  = r_fill;
    assign bus.free_space  = r_free;
    assign bus.overflow    = r_ovf;

endmodule
